// File: rtl/box_render_pkg.sv
// Shared constants for the box renderer: palette, error colour, darkening.
// Imported by box_hit and box_render.
package box_render_pkg;

   localparam logic [11:0] ERR_RGB = 12'hF0F;

   localparam logic [11:0] PALETTE [0:23] = '{
      12'hFFF, 12'hF00, 12'hFF0, 12'h0F0,
      12'h0FF, 12'h888, 12'hF80, 12'h00F,
      12'h800, 12'h080, 12'h008, 12'h880,
      12'h088, 12'h808, 12'h444, 12'hCCC,
      12'hF88, 12'h8F8, 12'h88F, 12'hFC0,
      12'h0CF, 12'hC0F, 12'h6A2, 12'h2A6
   };

   // Halve each 4-bit channel of {R,G,B}.
   function automatic logic [11:0] darken(input logic [11:0] c);
      return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
   endfunction

endpackage

// File: rtl/box_render_if.sv
// Pixel stream bundle: coordinate in, coloured pixel out.
// master drives i_pix_*, slave (the renderer) drives o_*.
interface box_render_if;
   import box_render_pkg::*;

   logic        i_pix_valid;
   logic [9:0]  i_pix_x;
   logic [9:0]  i_pix_y;
   logic [11:0] o_rgb;
   logic        o_rgb_valid;
   logic        o_hit1;
   logic        o_hit2;

   modport master (
      output i_pix_valid, i_pix_x, i_pix_y,
      input  o_rgb, o_rgb_valid, o_hit1, o_hit2
   );

   modport slave (
      input  i_pix_valid, i_pix_x, i_pix_y,
      output o_rgb, o_rgb_valid, o_hit1, o_hit2
   );

endinterface

// File: rtl/box_hit.sv
// Combinational box hit / border test for one box.
// Ports: pix_x/pix_y pixel, box_x/box_y top-left; hit, border out.
module box_hit
   import box_render_pkg::*;
#(
   parameter int BOX_W = 64,
   parameter int BOX_H = 48
) (
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic [9:0] box_x,
   input  logic [9:0] box_y,
   output logic       hit,
   output logic       border
);

   // 11-bit ends so a box past 1023 never wraps to low coordinates.
   logic [10:0] x_end;
   logic [10:0] y_end;
   logic [10:0] px;
   logic [10:0] py;
   logic        in_x;
   logic        in_y;
   logic        edge_x;
   logic        edge_y;

   assign px     = {1'b0, pix_x};
   assign py     = {1'b0, pix_y};
   assign x_end  = {1'b0, box_x} + 11'(BOX_W - 1);
   assign y_end  = {1'b0, box_y} + 11'(BOX_H - 1);
   assign in_x   = (pix_x >= box_x) && (px <= x_end);
   assign in_y   = (pix_y >= box_y) && (py <= y_end);
   assign edge_x = (pix_x == box_x) || (px == x_end);
   assign edge_y = (pix_y == box_y) || (py == y_end);
   assign hit    = in_x && in_y;
   assign border = hit && (edge_x || edge_y);

endmodule

// File: rtl/box_render.sv
// Two-stage per-pixel box renderer with per-frame shadow registers.
// Ports: clk_machine, rst_machine (async low), frame/box config, pix bus.
module box_render
   import box_render_pkg::*;
#(
   parameter int          BOX_W    = 64,
   parameter int          BOX_H    = 48,
   parameter logic [11:0] BG_RGB   = 12'hCCE,
   parameter int          PAL_SIZE = 24
) (
   input  logic       clk_machine,
   input  logic       rst_machine,
   input  logic       i_frame_start,
   input  logic [4:0] i_color_index1,
   input  logic [4:0] i_color_index2,
   input  logic [9:0] i_box1_x,
   input  logic [9:0] i_box1_y,
   input  logic [9:0] i_box2_x,
   input  logic [9:0] i_box2_y,
   box_render_if.slave pix
);

   // Shadow registers, loaded only on frame start to avoid tearing.
   logic [4:0] sh_idx1;
   logic [4:0] sh_idx2;
   logic [9:0] sh_b1x;
   logic [9:0] sh_b1y;
   logic [9:0] sh_b2x;
   logic [9:0] sh_b2y;

   always_ff @(posedge clk_machine or negedge rst_machine) begin
      if (!rst_machine) begin
         sh_idx1 <= '0;
         sh_idx2 <= '0;
         sh_b1x  <= '0;
         sh_b1y  <= '0;
         sh_b2x  <= '0;
         sh_b2y  <= '0;
      end else if (i_frame_start) begin
         sh_idx1 <= i_color_index1;
         sh_idx2 <= i_color_index2;
         sh_b1x  <= i_box1_x;
         sh_b1y  <= i_box1_y;
         sh_b2x  <= i_box2_x;
         sh_b2y  <= i_box2_y;
      end
   end

   logic hit1;
   logic hit2;
   logic bdr1;
   logic bdr2;

   box_hit #(.BOX_W(BOX_W), .BOX_H(BOX_H)) u_hit1 (
      .pix_x  (pix.i_pix_x),
      .pix_y  (pix.i_pix_y),
      .box_x  (sh_b1x),
      .box_y  (sh_b1y),
      .hit    (hit1),
      .border (bdr1)
   );

   box_hit #(.BOX_W(BOX_W), .BOX_H(BOX_H)) u_hit2 (
      .pix_x  (pix.i_pix_x),
      .pix_y  (pix.i_pix_y),
      .box_x  (sh_b2x),
      .box_y  (sh_b2y),
      .hit    (hit2),
      .border (bdr2)
   );

   // Stage 1 selection: box 1 drawn over box 2.
   logic [4:0] sel_idx_n;
   logic       sel_border_n;
   logic       sel_bg_n;

   always_comb begin
      sel_idx_n    = '0;
      sel_border_n = 1'b0;
      sel_bg_n     = 1'b0;
      if (hit1) begin
         sel_idx_n    = sh_idx1;
         sel_border_n = bdr1;
      end else if (hit2) begin
         sel_idx_n    = sh_idx2;
         sel_border_n = bdr2;
      end else begin
         sel_bg_n     = 1'b1;
      end
   end

   logic [4:0] s1_idx;
   logic       s1_border;
   logic       s1_bg;
   logic       s1_hit1;
   logic       s1_hit2;
   logic       s1_valid;

   always_ff @(posedge clk_machine or negedge rst_machine) begin
      if (!rst_machine) begin
         s1_idx    <= '0;
         s1_border <= 1'b0;
         s1_bg     <= 1'b0;
         s1_hit1   <= 1'b0;
         s1_hit2   <= 1'b0;
         s1_valid  <= 1'b0;
      end else begin
         s1_idx    <= sel_idx_n;
         s1_border <= sel_border_n;
         s1_bg     <= sel_bg_n;
         s1_hit1   <= hit1;
         s1_hit2   <= hit2;
         s1_valid  <= pix.i_pix_valid;
      end
   end

   // Stage 2 colour lookup; invalid pixels blank to zero.
   logic [11:0] rgb_n;
   logic [11:0] pal_rgb;

   always_comb begin
      rgb_n   = '0;
      pal_rgb = '0;
      if (s1_valid) begin
         if (s1_bg) begin
            rgb_n = BG_RGB;
         end else if (32'(s1_idx) >= PAL_SIZE) begin
            rgb_n = ERR_RGB;
         end else begin
            pal_rgb = PALETTE[s1_idx];
            rgb_n   = s1_border ? darken(pal_rgb) : pal_rgb;
         end
      end
   end

   always_ff @(posedge clk_machine or negedge rst_machine) begin
      if (!rst_machine) begin
         pix.o_rgb       <= '0;
         pix.o_rgb_valid <= 1'b0;
         pix.o_hit1      <= 1'b0;
         pix.o_hit2      <= 1'b0;
      end else begin
         pix.o_rgb       <= rgb_n;
         pix.o_rgb_valid <= s1_valid;
         pix.o_hit1      <= s1_valid && s1_hit1;
         pix.o_hit2      <= s1_valid && s1_hit2;
      end
   end

endmodule

// File: tb/tb_box_render.sv
// Directed table-driven bench for box_render.
// Drives on negedge, samples on negedge two cycles later.
module tb_box_render;
   import box_render_pkg::*;

   logic       clk_machine;
   logic       rst_machine;
   logic       i_frame_start;
   logic [4:0] i_color_index1;
   logic [4:0] i_color_index2;
   logic [9:0] i_box1_x;
   logic [9:0] i_box1_y;
   logic [9:0] i_box2_x;
   logic [9:0] i_box2_y;

   box_render_if pix ();

   box_render dut (
      .clk_machine    (clk_machine),
      .rst_machine    (rst_machine),
      .i_frame_start  (i_frame_start),
      .i_color_index1 (i_color_index1),
      .i_color_index2 (i_color_index2),
      .i_box1_x       (i_box1_x),
      .i_box1_y       (i_box1_y),
      .i_box2_x       (i_box2_x),
      .i_box2_y       (i_box2_y),
      .pix            (pix.slave)
   );

   initial clk_machine = 1'b0;
   always #20 clk_machine = ~clk_machine;

   typedef struct {
      string       name;
      logic [4:0]  idx1;
      logic [4:0]  idx2;
      logic [9:0]  b1x;
      logic [9:0]  b1y;
      logic [9:0]  b2x;
      logic [9:0]  b2y;
      logic [9:0]  px;
      logic [9:0]  py;
      logic        pv;
      logic [11:0] e_rgb;
      logic        e_val;
      logic        e_h1;
      logic        e_h2;
   } vec_t;

   vec_t vt [14];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string nm, input logic [11:0] act,
                      input logic [11:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [11:0] rgb,
                          input logic v, input logic h1,
                          input logic h2);
      chk({nm, ".rgb"}, pix.o_rgb, rgb);
      chk({nm, ".valid"}, 12'(pix.o_rgb_valid), 12'(v));
      chk({nm, ".hit1"}, 12'(pix.o_hit1), 12'(h1));
      chk({nm, ".hit2"}, 12'(pix.o_hit2), 12'(h2));
   endtask

   task automatic frame(input logic [4:0] a, input logic [4:0] b,
                        input logic [9:0] x1, input logic [9:0] y1,
                        input logic [9:0] x2, input logic [9:0] y2);
      @(negedge clk_machine);
      i_color_index1 = a;
      i_color_index2 = b;
      i_box1_x = x1;
      i_box1_y = y1;
      i_box2_x = x2;
      i_box2_y = y2;
      i_frame_start = 1'b1;
      @(negedge clk_machine);
      i_frame_start = 1'b0;
   endtask

   // Present one pixel, then idle; returns at the output sample point.
   task automatic one_pix(input logic [9:0] x, input logic [9:0] y,
                          input logic v);
      pix.i_pix_x = x;
      pix.i_pix_y = y;
      pix.i_pix_valid = v;
      @(negedge clk_machine);
      pix.i_pix_valid = 1'b0;
      @(negedge clk_machine);
   endtask

   initial begin
      vt[0]  = '{"interior", 3, 7, 100, 100, 600, 400, 130, 120, 1,
                 12'h0F0, 1, 1, 0};
      vt[1]  = '{"left_edge", 3, 7, 100, 100, 600, 400, 100, 120, 1,
                 12'h070, 1, 1, 0};
      vt[2]  = '{"left_out", 3, 7, 100, 100, 600, 400, 99, 120, 1,
                 12'hCCE, 1, 0, 0};
      vt[3]  = '{"overlap", 3, 7, 100, 100, 120, 110, 130, 120, 1,
                 12'h0F0, 1, 1, 1};
      vt[4]  = '{"box2_only", 3, 7, 100, 100, 120, 110, 170, 120, 1,
                 12'h00F, 1, 0, 1};
      vt[5]  = '{"bad_idx", 25, 7, 100, 100, 600, 400, 130, 120, 1,
                 12'hF0F, 1, 1, 0};
      vt[6]  = '{"bad_idx_edge", 25, 7, 100, 100, 600, 400, 100, 120, 1,
                 12'hF0F, 1, 1, 0};
      vt[7]  = '{"wrap_low", 3, 7, 100, 100, 1000, 100, 10, 120, 1,
                 12'hCCE, 1, 0, 0};
      vt[8]  = '{"wrap_in", 3, 7, 100, 100, 1000, 100, 1020, 120, 1,
                 12'h00F, 1, 0, 1};
      vt[9]  = '{"no_valid", 3, 7, 100, 100, 600, 400, 130, 120, 0,
                 12'h000, 0, 0, 0};
      vt[10] = '{"br_corner", 3, 7, 100, 100, 600, 400, 163, 147, 1,
                 12'h070, 1, 1, 0};
      vt[11] = '{"right_out", 3, 7, 100, 100, 600, 400, 164, 120, 1,
                 12'hCCE, 1, 0, 0};
      vt[12] = '{"white_edge", 0, 7, 100, 100, 600, 400, 130, 147, 1,
                 12'h777, 1, 1, 0};
      vt[13] = '{"idx23_in", 23, 7, 100, 100, 600, 400, 130, 120, 1,
                 12'h2A6, 1, 1, 0};

      rst_machine = 1'b0;
      i_frame_start = 1'b0;
      i_color_index1 = '0;
      i_color_index2 = '0;
      i_box1_x = '0;
      i_box1_y = '0;
      i_box2_x = '0;
      i_box2_y = '0;
      pix.i_pix_valid = 1'b0;
      pix.i_pix_x = '0;
      pix.i_pix_y = '0;
      repeat (3) @(negedge clk_machine);
      chk_all("reset", 12'h000, 0, 0, 0);
      rst_machine = 1'b1;
      @(negedge clk_machine);

      // Shadows are zero before the first frame start.
      one_pix(10'd5, 10'd5, 1'b1);
      chk_all("pre_frame", 12'hFFF, 1, 1, 1);
      one_pix(10'd0, 10'd0, 1'b1);
      chk_all("pre_frame_edge", 12'h777, 1, 1, 1);

      for (int i = 0; i < 14; i++) begin
         frame(vt[i].idx1, vt[i].idx2, vt[i].b1x, vt[i].b1y,
               vt[i].b2x, vt[i].b2y);
         one_pix(vt[i].px, vt[i].py, vt[i].pv);
         chk_all(vt[i].name, vt[i].e_rgb, vt[i].e_val,
                 vt[i].e_h1, vt[i].e_h2);
      end

      // Tearing guard: index change only lands after frame start.
      frame(3, 7, 100, 100, 600, 400);
      i_color_index1 = 5'd7;
      one_pix(10'd130, 10'd120, 1'b1);
      chk("tear_hold", pix.o_rgb, 12'h0F0);
      pix.i_pix_x = 10'd130;
      pix.i_pix_y = 10'd120;
      pix.i_pix_valid = 1'b1;
      i_frame_start = 1'b1;
      @(negedge clk_machine);
      i_frame_start = 1'b0;
      @(negedge clk_machine);
      chk("tear_same_cyc", pix.o_rgb, 12'h0F0);
      pix.i_pix_valid = 1'b0;
      @(negedge clk_machine);
      chk("tear_next", pix.o_rgb, 12'h00F);
      chk("tear_next_v", 12'(pix.o_rgb_valid), 12'h001);

      // Streaming: back-to-back pixels, one per cycle.
      frame(3, 7, 100, 100, 120, 110);
      pix.i_pix_x = 10'd130;
      pix.i_pix_y = 10'd120;
      pix.i_pix_valid = 1'b1;
      @(negedge clk_machine);
      pix.i_pix_x = 10'd170;
      @(negedge clk_machine);
      chk("stream0", pix.o_rgb, 12'h0F0);
      pix.i_pix_x = 10'd99;
      pix.i_pix_y = 10'd100;
      @(negedge clk_machine);
      chk("stream1", pix.o_rgb, 12'h00F);
      @(negedge clk_machine);
      chk("stream2", pix.o_rgb, 12'hCCE);

      // Mid-stream reset drops outputs immediately.
      pix.i_pix_x = 10'd130;
      pix.i_pix_y = 10'd120;
      @(posedge clk_machine);
      #5;
      rst_machine = 1'b0;
      #1;
      chk("rst_async_v", 12'(pix.o_rgb_valid), 12'h000);
      chk("rst_async_rgb", pix.o_rgb, 12'h000);
      pix.i_pix_valid = 1'b0;
      @(negedge clk_machine);
      rst_machine = 1'b1;
      @(negedge clk_machine);
      pix.i_pix_x = 10'd5;
      pix.i_pix_y = 10'd5;
      pix.i_pix_valid = 1'b1;
      @(negedge clk_machine);
      pix.i_pix_valid = 1'b0;
      chk("post_rst_1cyc", 12'(pix.o_rgb_valid), 12'h000);
      @(negedge clk_machine);
      chk("post_rst_2cyc", 12'(pix.o_rgb_valid), 12'h001);
      chk("post_rst_rgb", pix.o_rgb, 12'hFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/box_render.md
Name: box_render

Overview:
- Downstream consumer of the box colour generator, which supplies two 5-bit colour indices.
- Per pixel, decides whether the current VGA pixel lies inside box 1, box 2 or background, and returns a 12-bit RGB value.
- Latches colour indices and box geometry once per frame so a mid-frame index change never tears the image.
- Sits between the colour/position logic and the VGA output mux, in the 25 MHz pixel domain.

Parameters:
- BOX_W, 64: box width in pixels.
- BOX_H, 48: box height in pixels.
- BG_RGB, 12'hCCE: background colour.
- PAL_SIZE, 24: number of valid palette entries. Indices PAL_SIZE..31 are invalid.

Ports:
- clk_machine  in  1  pixel clock, 25 MHz.
- rst_machine  in  1  asynchronous reset, active-low.
- i_frame_start  in  1  one-cycle pulse at the start of each frame, before the first visible pixel.
- i_color_index1  in  5  box 1 colour index.
- i_color_index2  in  5  box 2 colour index.
- i_box1_x, i_box1_y  in  10 each  box 1 top-left corner.
- i_box2_x, i_box2_y  in  10 each  box 2 top-left corner.
- i_pix_valid  in  1  pixel coordinate valid (active video).
- i_pix_x, i_pix_y  in  10 each  current pixel coordinate.
- o_rgb  out  12  pixel colour {R[3:0],G[3:0],B[3:0]}.
- o_rgb_valid  out  1  o_rgb valid.
- o_hit1, o_hit2  out  1 each  pixel inside box 1 / box 2, aligned with o_rgb.

Behaviour:
- Reset (rst_machine=0, asynchronous): every output register goes to 0. This includes o_rgb=0, o_rgb_valid=0, o_hit1=0 and o_hit2=0. Latched indices and latched geometry also clear to 0, and the pipeline valid bits clear immediately.
- Frame latch:
  - On i_frame_start=1, capture both colour indices and all four coordinates into shadow registers.
  - The new values take effect from the next cycle.
  - A pixel presented in the same cycle as i_frame_start uses the old shadow values.
  - Before the first frame_start after reset, shadow values are 0.
- Hit test, stage 1:
  - hitN = pix_x >= bx && pix_x <= bx+BOX_W-1 && pix_y >= by && pix_y <= by+BOX_H-1.
  - Sums use 11-bit width, so a box extending past x=1023 or y=1023 never wraps to low coordinates.
  - Border flag: the pixel lies on the first or last row or column of the hit box.
  - Priority: box 1 is drawn over box 2. Select box 1's index and border flag when hit1 is set, otherwise box 2's when hit2 is set, otherwise the background.
  - Stage 1 registers sel_idx, sel_border, sel_bg, hit1, hit2 and valid.
- Colour, stage 2:
  - Background pixel: BG_RGB.
  - Index >= PAL_SIZE: error colour 12'hF0F.
  - Otherwise: PALETTE[idx].
  - Border pixel: each 4-bit channel shifted right by 1 (darkened). This does not apply to the background or to the error colour.
  - Stage 2 registers o_rgb, o_rgb_valid, o_hit1 and o_hit2.
- Latency: exactly 2 cycles from i_pix_* to o_*. Throughput is one pixel per cycle with no stalls.
- i_pix_valid=0:
  - o_rgb_valid=0 two cycles later.
  - o_rgb is forced to 0 (blanking-safe).
  - o_hit1 and o_hit2 are forced to 0.
- Reset asserted mid-line: outputs drop to 0 asynchronously. After release, the first valid output appears 2 cycles after the first i_pix_valid=1.

Decomposition:
- Shared package box_render_pkg holds:
  - PALETTE: 24-entry constant array of 12-bit RGB. Entry 0=12'hFFF, 3=12'h0F0, 7=12'h00F.
  - ERR_RGB=12'hF0F.
  - darken() function.
- One sub-module, box_hit, instantiated twice. It takes pixel coordinates, box x/y, BOX_W and BOX_H, and returns hit and border combinationally.

Test Plan:
- Reset then frame_start with idx1=3 and box1 at (100,100); pixel (130,120) valid → 2 cycles later o_rgb=12'h0F0, o_hit1=1, o_rgb_valid=1.
- Same setup, pixel (100,120) on the left edge → o_rgb=12'h070. Pixel (99,120) → o_rgb=12'hCCE with o_hit1=0.
- Overlap: box1 at (100,100) idx 3, box2 at (120,110) idx 7; pixel (130,120) → 12'h0F0 with o_hit1=1 and o_hit2=1. Pixel (170,120) → 12'h00F.
- Invalid index: idx1=25, interior pixel → 12'hF0F.
- Tearing guard: change i_color_index1 from 3 to 7 mid-frame → output stays 12'h0F0 until the cycle after the next frame_start, then 12'h00F.
- Wrap guard: box2 at x=1000, pixel x=10 inside the y range → no hit, 12'hCCE. Also assert rst_machine mid-stream → o_rgb_valid=0 immediately.
